posit_field_extract: RTL and testbench



---
 rtl/posit_field_extract.sv | 154 +++++++++++++++
 tb/tb_posit_field_extract.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/posit_field_extract.sv
// Iterative posit decode front-end: splits one posit word into sign, regime,
// exponent and fraction fields, counting the regime run one bit per cycle.
module posit_field_extract #(
  parameter int unsigned BITS  = 32,
  parameter int unsigned ES    = 2,
  parameter int unsigned WIDTH = $clog2(BITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BITS-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic             out_zero,
  output logic             out_nar,
  output logic [WIDTH:0]   out_k,
  output logic [BITS-1:0]  out_run,
  output logic [ES-1:0]    out_exp,
  output logic [BITS-1:0]  out_frac
);

  typedef enum logic [1:0] {StIdle, StConv, StScan, StDone} state_e;

  localparam logic [BITS-1:0]  NarWord = {1'b1, {(BITS-1){1'b0}}};
  localparam logic [BITS-1:0]  WordOne = {{(BITS-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CntMax  = WIDTH'(BITS-1);
  localparam logic [WIDTH-1:0] CntOne  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   KOne    = {{WIDTH{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [BITS-1:0]   rem_q, rem_d;
  logic              r0_q, r0_d;
  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic              zero_q, zero_d;
  logic              nar_q, nar_d;
  logic [WIDTH:0]    k_q, k_d;
  logic [BITS-1:0]   run_q, run_d;
  logic [ES-1:0]     exp_q, exp_d;
  logic [BITS-1:0]   frac_q, frac_d;

  logic [BITS-1:0]   mag;
  logic [BITS-1:0]   rem_skip;
  logic [WIDTH:0]    cnt_ext;

  // Next-state and datapath: capture, magnitude, serial regime scan, field split
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    r0_d    = r0_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    nar_d   = nar_q;
    k_d     = k_q;
    run_d   = run_q;
    exp_d   = exp_q;
    frac_d  = frac_q;

    // rem_q holds the raw word during StConv
    mag      = sign_q ? (~rem_q + WordOne) : rem_q;
    // Skip the terminating bit unless the run saturated the whole word
    rem_skip = (cnt_q < CntMax) ? (rem_q << 1) : rem_q;
    cnt_ext  = {1'b0, cnt_q};

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          rem_d  = in_data;
          zero_d = (in_data == '0);
          nar_d  = (in_data == NarWord);
          k_d    = '0;
          run_d  = '0;
          exp_d  = '0;
          frac_d = '0;
          if ((in_data == '0) || (in_data == NarWord)) begin
            sign_d  = 1'b0;
            state_d = StDone;
          end else begin
            sign_d  = in_data[BITS-1];
            state_d = StConv;
          end
        end
      end
      StConv: begin
        rem_d   = mag << 1;
        r0_d    = mag[BITS-2];
        cnt_d   = '0;
        state_d = StScan;
      end
      StScan: begin
        if ((rem_q[BITS-1] == r0_q) && (cnt_q < CntMax)) begin
          cnt_d = cnt_q + CntOne;
          rem_d = rem_q << 1;
        end else begin
          exp_d   = rem_skip[BITS-1 -: ES];
          frac_d  = rem_skip << ES;
          run_d   = {{(BITS-WIDTH){1'b0}}, cnt_q};
          k_d     = r0_q ? (cnt_ext - KOne) : -cnt_ext;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and field registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      r0_q    <= 1'b0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      nar_q   <= 1'b0;
      k_q     <= '0;
      run_q   <= '0;
      exp_q   <= '0;
      frac_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      r0_q    <= r0_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      nar_q   <= nar_d;
      k_q     <= k_d;
      run_q   <= run_d;
      exp_q   <= exp_d;
      frac_q  <= frac_d;
    end
  end

  // Handshake and field outputs straight from registers
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    out_sign  = sign_q;
    out_zero  = zero_q;
    out_nar   = nar_q;
    out_k     = k_q;
    out_run   = run_q;
    out_exp   = exp_q;
    out_frac  = frac_q;
  end

endmodule

// File: tb/tb_posit_field_extract.sv
// Randomized and directed bench for posit_field_extract at BITS=8, ES=1.
module tb_posit_field_extract;

  localparam int unsigned BITS  = 8;
  localparam int unsigned ES    = 1;
  localparam int unsigned WIDTH = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [BITS-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic             out_zero;
  logic             out_nar;
  logic [WIDTH:0]   out_k;
  logic [BITS-1:0]  out_run;
  logic [ES-1:0]    out_exp;
  logic [BITS-1:0]  out_frac;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit         sign;
    bit         zero;
    bit         nar;
    int         k;
    int         run;
    int         expo;
    logic [7:0] frac;
    int         lat;
  } ref_t;

  posit_field_extract #(
    .BITS (BITS),
    .ES   (ES),
    .WIDTH(WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sign (out_sign),
    .out_zero (out_zero),
    .out_nar  (out_nar),
    .out_k    (out_k),
    .out_run  (out_run),
    .out_exp  (out_exp),
    .out_frac (out_frac)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference decode: walk the magnitude bit by bit from just below the sign
  function automatic ref_t model(input logic [7:0] w);
    ref_t e;
    logic [7:0] mag;
    bit r0;
    int pos;
    e.sign = 0; e.zero = 0; e.nar = 0; e.k = 0; e.run = 0; e.expo = 0;
    e.frac = 8'h00; e.lat = 1;
    if (w == 8'h00) begin
      e.zero = 1;
      return e;
    end
    if (w == 8'h80) begin
      e.nar = 1;
      return e;
    end
    e.sign = w[7];
    mag = w[7] ? 8'(256 - int'(w)) : w;
    r0 = mag[6];
    pos = 6;
    while (pos >= 0 && mag[pos] == r0) begin
      e.run++;
      pos--;
    end
    // pos now indexes the terminator, or -1 when the run filled every bit
    if (pos - 1 >= 0) e.expo = int'(mag[pos-1]);
    if (pos - 2 >= 0) e.frac = mag << (8 - (pos - 1));
    e.k   = r0 ? e.run - 1 : -e.run;
    e.lat = e.run + 2;
    return e;
  endfunction

  task automatic check_fields(input string tag, input ref_t e);
    logic [3:0] kexp;
    kexp = 4'(e.k);
    check_eq({tag, ".sign"}, 32'(out_sign), 32'(e.sign));
    check_eq({tag, ".zero"}, 32'(out_zero), 32'(e.zero));
    check_eq({tag, ".nar"},  32'(out_nar),  32'(e.nar));
    check_eq({tag, ".k"},    32'(out_k),    32'(kexp));
    check_eq({tag, ".run"},  32'(out_run),  32'(e.run));
    check_eq({tag, ".exp"},  32'(out_exp),  32'(e.expo));
    check_eq({tag, ".frac"}, 32'(out_frac), 32'(e.frac));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".in_ready"},  32'(in_ready),  32'd1);
    check_eq({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, ".fields"},
             32'({out_sign, out_zero, out_nar, out_k, out_run, out_exp, out_frac}), 32'd0);
  endtask

  // Send one word, check latency and fields, hold backpressure, then release
  task automatic send(input logic [7:0] w, input int hold);
    ref_t e;
    int lat;
    string tag;
    e = model(w);
    tag = $sformatf("w%02h", w);
    check_eq({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    lat = 0;
    while (lat < 20) begin
      if (lat > 0 && out_valid) break;
      @(posedge clk);
      #1;
      lat++;
      in_data = 8'($urandom);
    end
    check_eq({tag, ".latency"}, 32'(lat), 32'(e.lat));
    if (!out_valid) return;
    check_fields(tag, e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_eq({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
      check_fields({tag, ".hold"}, e);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, ".post_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, ".post_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] directed [8];
    int saw_valid;
    directed = '{8'h40, 8'h5A, 8'hC0, 8'h7F, 8'h01, 8'h00, 8'h80, 8'hFF};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    foreach (directed[i]) send(directed[i], 0);
    send(8'h5A, 5);

    for (int i = 0; i < 40; i++) send(8'($urandom), int'($urandom_range(0, 2)));

    // Reset while scanning a long regime run
    send(8'h7F, 0);
    in_valid = 1'b1;
    in_data  = 8'h7F;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("scan_reset");
    saw_valid = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) saw_valid = 1;
    end
    check_eq("scan_reset.no_valid", 32'(saw_valid), 32'd0);

    send(8'h5A, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
